// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: CPU data-SRAM request/response bus
//   master drives req, wr, wstrb, addr, wdata; slave drives addr_ok, data_ok, rdata
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: byte-masked data SRAM with fixed-latency in-order responses
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave end of data_sram_responder_if (req/wr/wstrb/addr/wdata in, addr_ok/data_ok/rdata out)
//   MEM_STALL_EN : when defined, an LFSR gates addr_ok to inject pseudo-random request stalls
module data_sram_responder #(
  parameter int ADDR_W          = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                  clk,
  input logic                  reset,
  data_sram_responder_if.slave bus
);
  logic [31:0]        mem [2**ADDR_W];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx;
  logic               acc, stall_ok, addr_unused;
`ifdef MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) lfsr_q <= reset ? 16'hACE1 : lfsr_d;
  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif
  assign addr_unused = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
  always_comb begin
    idx         = bus.addr[ADDR_W+1:2];
    bus.addr_ok = (cnt_q < 4'(MAX_OUTSTANDING)) && !reset && stall_ok;
    acc         = bus.req && bus.addr_ok;
    vld_d[0]    = acc;
    dat_d[0]    = (acc && !bus.wr) ? mem[idx] : 32'h0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    // the slot is released at the edge that launches data_ok, so it can be reused in the data_ok cycle
    cnt_d = cnt_q + 4'(acc) - 4'(vld_d[LATENCY-1]);
  end
  assign bus.data_ok = vld_q[LATENCY-1];
  assign bus.rdata   = dat_q[LATENCY-1];
  always_ff @(posedge clk) begin
    vld_q <= reset ? '0 : vld_d;
    cnt_q <= reset ? '0 : cnt_d;
    for (int i = 0; i < LATENCY; i++) dat_q[i] <= reset ? 32'h0 : dat_d[i];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (acc && bus.wr && bus.wstrb[i]) mem[idx][8*i+:8] <= bus.wdata[8*i+:8];
endmodule
